// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiters.
// Port indices follow router order N, S, W, E, L.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_W = 2;
    localparam int PORT_E = 3;
    localparam int PORT_L = 4;

    localparam int DEF_ADDR_W = 3;

    // Next index after idx, wrapping back to 0 past n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: picks the first set req bit at or after ptr,
// wrapping modulo N, and reports it as one-hot and binary.
module rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk N positions starting at ptr; the first hit wins.
    always_comb begin
        int   k;
        logic found;
        k      = 0;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = W'(k);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// Round-robin, packet-locked arbiter for one router output port.
// A grant holds until the tail flit fires or MAX_HOLD cycles elapse.
module rr_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_IN   = 5,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PORT_ID  = 1,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(NUM_IN),
    localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*ADDR_W-1:0] nexthop_addr_i,
    input  logic [NUM_IN-1:0]        valid_i,
    input  logic [NUM_IN-1:0]        tail_i,
    input  logic                     ready_i,
    output logic [NUM_IN-1:0]        grant_o,
    output logic [IDX_W-1:0]         grant_idx_o,
    output logic                     grant_valid_o,
    output logic                     fire_o,
    output logic                     timeout_o
);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  hold_cnt;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              tail_fire;
    logic              hold_max;
    logic              release_now;

    // Requests aimed at this port; the U-turn input never competes.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_req
        assign req[k] = valid_i[k]
            & (nexthop_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
            & (k != PORT_ID);
    end

    rr_pick #(
        .N (NUM_IN),
        .W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Transfer, tail-release and forced-release conditions.
    always_comb begin
        fire_o = grant_valid_o & valid_i[grant_idx_o] & ready_i;
        tail_fire = fire_o & tail_i[grant_idx_o];
        hold_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        timeout_o = (state == ARB_LOCKED) & hold_max & ~tail_fire;
        release_now = tail_fire | timeout_o;
    end

    // Arbitration FSM: grab a winner in IDLE, hold it until release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            grant_o       <= '0;
            grant_idx_o   <= '0;
            grant_valid_o <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state         <= ARB_LOCKED;
                        grant_o       <= pick_onehot;
                        grant_idx_o   <= pick_idx;
                        grant_valid_o <= 1'b1;
                        hold_cnt      <= '0;
                    end
                end
                ARB_LOCKED: begin
                    if (release_now) begin
                        state         <= ARB_IDLE;
                        grant_o       <= '0;
                        grant_idx_o   <= '0;
                        grant_valid_o <= 1'b0;
                        hold_cnt      <= '0;
                        ptr <= IDX_W'(wrap_inc(int'(grant_idx_o), NUM_IN));
                    end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter: default instance plus a
// MAX_HOLD=4 instance sharing the same stimulus.
module tb_rr_output_arbiter;

    logic        clk;
    logic        reset;
    logic [14:0] addr;
    logic [4:0]  valid;
    logic [4:0]  tail;
    logic        ready;

    logic [4:0] g, g4;
    logic [2:0] gi, gi4;
    logic       gv, gv4;
    logic       f, f4;
    logic       to, to4;

    int n_chk;
    int n_fail;

    localparam logic [14:0] ADDR_ALL_S = {5{3'd1}};

    rr_output_arbiter #(
        .NUM_IN(5), .ADDR_W(3), .PORT_ID(1), .MAX_HOLD(16)
    ) dut (
        .clk(clk), .reset(reset), .nexthop_addr_i(addr),
        .valid_i(valid), .tail_i(tail), .ready_i(ready),
        .grant_o(g), .grant_idx_o(gi), .grant_valid_o(gv),
        .fire_o(f), .timeout_o(to)
    );

    rr_output_arbiter #(
        .NUM_IN(5), .ADDR_W(3), .PORT_ID(1), .MAX_HOLD(4)
    ) dut4 (
        .clk(clk), .reset(reset), .nexthop_addr_i(addr),
        .valid_i(valid), .tail_i(tail), .ready_i(ready),
        .grant_o(g4), .grant_idx_o(gi4), .grant_valid_o(gv4),
        .fire_o(f4), .timeout_o(to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid = '0;
        tail  = '0;
        ready = 1'b1;
        addr  = ADDR_ALL_S;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (g !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_grant got=%b exp=%b", g, 5'b0);
        end
        n_chk++;
        if (gi !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_idx got=%0d exp=0", gi);
        end
        n_chk++;
        if (gv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_gv got=%b exp=0", gv);
        end
        n_chk++;
        if (to !== 1'b0 || f !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_to_fire got=%b%b exp=00", to, f);
        end
        valid = 5'b10101;
        tick();
        n_chk++;
        if (g !== 5'b0 || gv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold got=%b exp=%b", g, 5'b0);
        end
        valid = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_rr_order();
        do_reset();
        valid = 5'b10101;
        #1;
        n_chk++;
        if (g !== 5'b0) begin
            n_fail++;
            $display("FAIL rr_pre got=%b exp=%b", g, 5'b0);
        end
        tick();
        n_chk++;
        if (g !== 5'b00001 || gi !== 3'd0 || gv !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant_n got=%b/%0d exp=00001/0", g, gi);
        end
        n_chk++;
        if (f !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_fire1 got=%b exp=1", f);
        end
        tick();
        tick();
        tail = 5'b00001;
        #1;
        n_chk++;
        if (g !== 5'b00001 || f !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_tail got=%b/%b exp=00001/1", g, f);
        end
        tick();
        tail = '0;
        n_chk++;
        if (g !== 5'b0 || gv !== 1'b0 || gi !== 3'd0) begin
            n_fail++;
            $display("FAIL rr_bubble1 got=%b/%0d exp=00000/0", g, gi);
        end
        tick();
        n_chk++;
        if (g !== 5'b00100 || gi !== 3'd2) begin
            n_fail++;
            $display("FAIL rr_grant_w got=%b/%0d exp=00100/2", g, gi);
        end
        tail = 5'b00100;
        tick();
        tail = '0;
        n_chk++;
        if (g !== 5'b0) begin
            n_fail++;
            $display("FAIL rr_bubble2 got=%b exp=%b", g, 5'b0);
        end
        tick();
        n_chk++;
        if (g !== 5'b10000 || gi !== 3'd4) begin
            n_fail++;
            $display("FAIL rr_grant_l got=%b/%0d exp=10000/4", g, gi);
        end
        tail = 5'b10000;
        tick();
        tail  = '0;
        valid = '0;
        n_chk++;
        if (g !== 5'b0) begin
            n_fail++;
            $display("FAIL rr_release_l got=%b exp=%b", g, 5'b0);
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        valid = 5'b01000;
        tail  = 5'b01000;
        ready = 1'b0;
        tick();
        n_chk++;
        if (g !== 5'b01000 || gi !== 3'd3) begin
            n_fail++;
            $display("FAIL stall_grant got=%b/%0d exp=01000/3", g, gi);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (f !== 1'b0 || g !== 5'b01000) begin
                n_fail++;
                $display("FAIL stall_hold%0d got=%b/%b exp=0/01000",
                         i, f, g);
            end
            tick();
        end
        ready = 1'b1;
        #1;
        n_chk++;
        if (f !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_fire got=%b exp=1", f);
        end
        tick();
        valid = '0;
        tail  = '0;
        n_chk++;
        if (g !== 5'b0 || gv !== 1'b0 || f !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bubble got=%b/%b exp=00000/0", g, gv);
        end
        tick();
        n_chk++;
        if (g !== 5'b0) begin
            n_fail++;
            $display("FAIL stall_idle got=%b exp=%b", g, 5'b0);
        end
    endtask

    task automatic test_uturn();
        do_reset();
        addr  = {3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        valid = 5'b00011;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (g !== 5'b0 || gv !== 1'b0) begin
                n_fail++;
                $display("FAIL uturn%0d got=%b/%b exp=00000/0", i, g, gv);
            end
        end
        valid = '0;
        addr  = ADDR_ALL_S;
    endtask

    task automatic test_timeout();
        do_reset();
        valid = 5'b01100;
        tick();
        for (int i = 1; i <= 4; i++) begin
            n_chk++;
            if (to4 !== (i == 4) || g4 !== 5'b00100) begin
                n_fail++;
                $display("FAIL tmo_cyc%0d got=%b/%b exp=%b/00100",
                         i, to4, g4, (i == 4));
            end
            tick();
        end
        n_chk++;
        if (g4 !== 5'b0 || to4 !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_bubble got=%b/%b exp=00000/0", g4, to4);
        end
        tick();
        n_chk++;
        if (g4 !== 5'b01000 || gi4 !== 3'd3) begin
            n_fail++;
            $display("FAIL tmo_next_e got=%b/%0d exp=01000/3", g4, gi4);
        end
        valid = '0;
    endtask

    task automatic test_tail_timeout();
        do_reset();
        valid = 5'b00100;
        ready = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            n_chk++;
            if (to4 !== 1'b0) begin
                n_fail++;
                $display("FAIL tt_early%0d got=%b exp=0", i, to4);
            end
            tick();
        end
        ready = 1'b1;
        tail  = 5'b00100;
        #1;
        n_chk++;
        if (f4 !== 1'b1 || to4 !== 1'b0) begin
            n_fail++;
            $display("FAIL tt_coincide got=%b/%b exp=1/0", f4, to4);
        end
        tick();
        tail  = '0;
        valid = '0;
        n_chk++;
        if (g4 !== 5'b0 || to4 !== 1'b0) begin
            n_fail++;
            $display("FAIL tt_release got=%b/%b exp=00000/0", g4, to4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 5'b00001;
        tail  = 5'b00001;
        tick();
        tick();
        valid = 5'b10000;
        tail  = '0;
        tick();
        n_chk++;
        if (g !== 5'b10000 || gi !== 3'd4) begin
            n_fail++;
            $display("FAIL rm_grant_l got=%b/%0d exp=10000/4", g, gi);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if (g !== 5'b0 || gv !== 1'b0 || gi !== 3'd0) begin
            n_fail++;
            $display("FAIL rm_drop got=%b/%0d exp=00000/0", g, gi);
        end
        n_chk++;
        if (f !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_nofire got=%b exp=0", f);
        end
        reset = 1'b1;
        valid = 5'b10101;
        tick();
        n_chk++;
        if (g !== 5'b00001 || gi !== 3'd0) begin
            n_fail++;
            $display("FAIL rm_restart got=%b/%0d exp=00001/0", g, gi);
        end
        valid = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        valid  = '0;
        tail   = '0;
        ready  = 1'b1;
        addr   = ADDR_ALL_S;
        test_reset();
        test_rr_order();
        test_ready_stall();
        test_uturn();
        test_timeout();
        test_tail_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
